// File: rtl/sc_core_oz_alu_issue.sv
// Single-issue RV32I ALU instruction sequencer: captures one instruction,
// decodes it against the register file, drives an external ALU for one
// cycle and writes the result back. One instruction in flight at a time.

package sc_core_oz_alu_issue_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef struct packed {
        alu_op_e     op;
        logic [31:0] reg_src1;
        logic [31:0] reg_src2;
    } m_alu_ctrl;

endpackage

module sc_core_oz_alu_issue
    import sc_core_oz_alu_issue_pkg::*;
#(
    parameter int          REG_CNT     = 32,
    parameter logic [31:0] RST_REG_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output m_alu_ctrl   alu_ctrl,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_rd_addr,
    output logic [31:0] dbg_rd_data
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    alu_op_e     op_q, op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic [31:0] regs_q [REG_CNT];
    logic [31:0] regs_d [REG_CNT];

    // Decode outputs
    logic        dec_legal;
    alu_op_e     dec_op;
    logic [31:0] dec_src1;
    logic [31:0] dec_src2;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_i;

    // x0 and addresses beyond the implemented file read as zero
    function automatic logic [31:0] rf_read(input logic [4:0] addr);
        logic [31:0] val;
        val = '0;
        if (addr != 5'd0 && int'(addr) < REG_CNT) begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    assign opcode      = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7      = instr_q[31:25];
    assign rs1_val     = rf_read(instr_q[19:15]);
    assign rs2_val     = rf_read(instr_q[24:20]);
    assign imm_i       = {{20{instr_q[31]}}, instr_q[31:20]};
    assign dbg_rd_data = rf_read(dbg_rd_addr);

    // Classify the captured instruction and build ALU operands
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_src1  = rs1_val;
        dec_src2  = '0;
        if (opcode == OPC_OP) begin
            // funct7 0x20 only selects SUB / SRA; all other non-zero funct7 are rejected
            dec_legal = (funct7 == F7_BASE) ||
                        (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5));
            dec_src2  = rs2_val;
            case (funct3)
                3'd0:    dec_op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                3'd1:    begin dec_op = ALU_SLL; dec_src2 = {27'd0, rs2_val[4:0]}; end
                3'd2:    dec_op = ALU_SLT;
                3'd3:    dec_op = ALU_SLTU;
                3'd4:    dec_op = ALU_XOR;
                3'd5:    begin
                    dec_op   = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    dec_src2 = {27'd0, rs2_val[4:0]};
                end
                3'd6:    dec_op = ALU_OR;
                default: dec_op = ALU_AND;
            endcase
        end else if (opcode == OPC_OP_IMM) begin
            dec_legal = 1'b1;
            dec_src2  = imm_i;
            case (funct3)
                3'd0:    dec_op = ALU_ADD;
                3'd1:    begin
                    dec_op    = ALU_SLL;
                    dec_src2  = {27'd0, instr_q[24:20]};
                    dec_legal = (funct7 == F7_BASE);
                end
                3'd2:    dec_op = ALU_SLT;
                3'd3:    dec_op = ALU_SLTU;
                3'd4:    dec_op = ALU_XOR;
                3'd5:    begin
                    dec_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    dec_src2  = {27'd0, instr_q[24:20]};
                    dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end
                3'd6:    dec_op = ALU_OR;
                default: dec_op = ALU_AND;
            endcase
        end
    end

    // Sequencer: next state, datapath register updates and outputs
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        rd_d     = rd_q;
        result_d = result_q;
        regs_d   = regs_q;

        instr_ready       = 1'b0;
        illegal           = 1'b0;
        wb_valid          = 1'b0;
        wb_rd             = '0;
        wb_data           = '0;
        alu_ctrl.op       = ALU_ADD;
        alu_ctrl.reg_src1 = '0;
        alu_ctrl.reg_src2 = '0;

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    op_d    = dec_op;
                    src1_d  = dec_src1;
                    src2_d  = dec_src2;
                    rd_d    = instr_q[11:7];
                    state_d = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                alu_ctrl.op       = op_q;
                alu_ctrl.reg_src1 = src1_q;
                alu_ctrl.reg_src2 = src2_q;
                result_d          = alu_result;
                state_d           = S_WB;
            end
            default: begin
                wb_valid = 1'b1;
                wb_rd    = rd_q;
                wb_data  = result_q;
                if (rd_q != 5'd0 && int'(rd_q) < REG_CNT) begin
                    regs_d[rd_q] = result_q;
                end
                state_d = S_IDLE;
            end
        endcase
    end

    // State and register-file update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            op_q     <= ALU_ADD;
            src1_q   <= '0;
            src2_q   <= '0;
            rd_q     <= '0;
            result_q <= '0;
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= (i == 0) ? 32'h0 : RST_REG_VAL;
            end
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sc_core_oz_alu_issue.sv
// Self-checking bench for sc_core_oz_alu_issue: directed vector table,
// randomized instructions against an architectural model, and hand-written
// multi-cycle sequences (held instr_valid, reset during EXEC).

module tb_sc_core_oz_alu_issue;
    import sc_core_oz_alu_issue_pkg::*;

    localparam logic [31:0] RST_VAL = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    m_alu_ctrl   alu_ctrl;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_rd_addr = '0;
    logic [31:0] dbg_rd_data;

    sc_core_oz_alu_issue #(.REG_CNT(32), .RST_REG_VAL(RST_VAL)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal),
        .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data)
    );

    always #5 clk = ~clk;

    // External ALU seen by the issuer
    always_comb begin
        alu_result = '0;
        case (alu_ctrl.op)
            ALU_ADD:  alu_result = alu_ctrl.reg_src1 + alu_ctrl.reg_src2;
            ALU_SUB:  alu_result = alu_ctrl.reg_src1 - alu_ctrl.reg_src2;
            ALU_SLL:  alu_result = alu_ctrl.reg_src1 << alu_ctrl.reg_src2[4:0];
            ALU_SLT:  alu_result = {31'd0, $signed(alu_ctrl.reg_src1) < $signed(alu_ctrl.reg_src2)};
            ALU_SLTU: alu_result = {31'd0, alu_ctrl.reg_src1 < alu_ctrl.reg_src2};
            ALU_XOR:  alu_result = alu_ctrl.reg_src1 ^ alu_ctrl.reg_src2;
            ALU_SRL:  alu_result = alu_ctrl.reg_src1 >> alu_ctrl.reg_src2[4:0];
            ALU_SRA:  alu_result = $signed(alu_ctrl.reg_src1) >>> alu_ctrl.reg_src2[4:0];
            ALU_OR:   alu_result = alu_ctrl.reg_src1 | alu_ctrl.reg_src2;
            ALU_AND:  alu_result = alu_ctrl.reg_src1 & alu_ctrl.reg_src2;
            default:  alu_result = '0;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Architectural model: register file and per-instruction semantics
    logic [31:0] mreg [32];

    function automatic void model_reset();
        mreg[0] = 32'h0;
        for (int i = 1; i < 32; i++) mreg[i] = RST_VAL;
    endfunction

    function automatic bit model_exec(input logic [31:0] ins, output logic [31:0] res);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b;
        logic [4:0]  sh;
        bit          is_r, alt, ok;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        a   = mreg[ins[19:15]];
        res = '0;
        is_r = (opc == 7'b0110011);
        if (is_r) begin
            b   = mreg[ins[24:20]];
            alt = (f7 == 7'h20);
            ok  = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
        end else if (opc == 7'b0010011) begin
            b   = {{20{ins[31]}}, ins[31:20]};
            alt = (f3 == 3'd5) && (f7 == 7'h20);
            if (f3 == 3'd1)      ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            else                 ok = 1'b1;
        end else begin
            return 1'b0;
        end
        if (!ok) return 1'b0;
        sh = b[4:0];
        case (f3)
            3'd0: res = (is_r && alt) ? a - b : a + b;
            3'd1: res = a << sh;
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: res = a | b;
            default: res = a & b;
        endcase
        return 1'b1;
    endfunction

    function automatic void model_commit(input logic [31:0] ins);
        logic [31:0] r;
        if (model_exec(ins, r) && ins[11:7] != 5'd0) mreg[ins[11:7]] = r;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk({name, "_ready_timeout"}, 32'(instr_ready), 32'd1);
    endtask

    task automatic dbg_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        dbg_rd_addr = a;
        #1;
        chk(name, dbg_rd_data, exp);
    endtask

    // Issue one instruction and check its full cycle-by-cycle behaviour
    task automatic run_instr(input string name, input logic [31:0] ins, input bit exp_ill,
                             input logic [4:0] exp_rd, input logic [31:0] exp_data,
                             input bit chk_alu, input alu_op_e exp_op,
                             input logic [31:0] exp_src2);
        wait_ready(name);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        @(negedge clk);  // N+1
        chk({name, "_illegal_n1"}, 32'(illegal), 32'(exp_ill));
        chk({name, "_wbv_n1"}, 32'(wb_valid), 32'd0);
        chk({name, "_ready_n1"}, 32'(instr_ready), 32'd0);
        if (exp_ill) begin
            @(negedge clk);  // N+2
            chk({name, "_ready_n2"}, 32'(instr_ready), 32'd1);
            chk({name, "_illegal_n2"}, 32'(illegal), 32'd0);
            chk({name, "_wbv_n2"}, 32'(wb_valid), 32'd0);
        end else begin
            @(negedge clk);  // N+2
            if (chk_alu) begin
                chk({name, "_op"}, 32'(alu_ctrl.op), 32'(exp_op));
                chk({name, "_src2"}, alu_ctrl.reg_src2, exp_src2);
            end
            chk({name, "_wbv_n2"}, 32'(wb_valid), 32'd0);
            @(negedge clk);  // N+3
            chk({name, "_wbv_n3"}, 32'(wb_valid), 32'd1);
            chk({name, "_wb_rd"}, 32'(wb_rd), 32'(exp_rd));
            chk({name, "_wb_data"}, wb_data, exp_data);
            @(negedge clk);  // N+4
            chk({name, "_ready_n4"}, 32'(instr_ready), 32'd1);
            chk({name, "_wbv_n4"}, 32'(wb_valid), 32'd0);
            chk({name, "_wb_data_idle"}, wb_data, 32'd0);
            chk({name, "_wb_rd_idle"}, 32'(wb_rd), 32'd0);
            dbg_chk({name, "_dbg_rd"}, exp_rd, (exp_rd == 5'd0) ? 32'd0 : exp_data);
        end
        model_commit(ins);
    endtask

    typedef struct {
        string       name;
        logic [31:0] ins;
        bit          ill;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          chk_alu;
        alu_op_e     op;
        logic [31:0] src2;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [31:0] ins, input bit ill,
                                input logic [4:0] rd, input logic [31:0] data,
                                input bit chk_alu, input alu_op_e op, input logic [31:0] src2);
        vec_t v;
        v.name = name; v.ins = ins; v.ill = ill; v.rd = rd; v.data = data;
        v.chk_alu = chk_alu; v.op = op; v.src2 = src2;
        return v;
    endfunction

    vec_t vecs [12];

    initial begin
        logic [31:0] ins, r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        bit          ok;
        int          k;

        vecs[0]  = mk("addi_x1_m5",  32'hFFB00093, 0, 5'd1, 32'hFFFF_FFFB, 1, ALU_ADD, 32'hFFFF_FFFB);
        vecs[1]  = mk("addi_x2_2",   enc_i(12'd2, 5'd0, 3'd0, 5'd2), 0, 5'd2, 32'd2, 0, ALU_ADD, 32'd0);
        vecs[2]  = mk("sra_x3",      enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd3), 0, 5'd3, 32'hFFFF_FFFE, 1, ALU_SRA, 32'd2);
        vecs[3]  = mk("sltu_x4",     enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd4), 0, 5'd4, 32'd1, 1, ALU_SLTU, 32'hFFFF_FFFB);
        vecs[4]  = mk("addi_x2_24",  enc_i(12'h024, 5'd0, 3'd0, 5'd2), 0, 5'd2, 32'h24, 0, ALU_ADD, 32'd0);
        vecs[5]  = mk("sll_x5",      enc_r(7'h00, 5'd2, 5'd2, 3'd1, 5'd5), 0, 5'd5, 32'h240, 1, ALU_SLL, 32'd4);
        vecs[6]  = mk("ill_load",    32'h0000_0003, 1, 5'd0, 32'd0, 0, ALU_ADD, 32'd0);
        vecs[7]  = mk("ill_f7_01",   enc_r(7'h01, 5'd1, 5'd1, 3'd0, 5'd1), 1, 5'd0, 32'd0, 0, ALU_ADD, 32'd0);
        vecs[8]  = mk("addi_x0_7",   enc_i(12'd7, 5'd0, 3'd0, 5'd0), 0, 5'd0, 32'd7, 0, ALU_ADD, 32'd0);
        vecs[9]  = mk("sub_x6",      enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd6), 0, 5'd6, 32'd5, 1, ALU_SUB, 32'hFFFF_FFFB);
        vecs[10] = mk("srai_x7",     enc_i(12'h401, 5'd1, 3'd5, 5'd7), 0, 5'd7, 32'hFFFF_FFFD, 1, ALU_SRA, 32'd1);
        vecs[11] = mk("ill_slli_f7", enc_i(12'h021, 5'd1, 3'd1, 5'd8), 1, 5'd0, 32'd0, 0, ALU_ADD, 32'd0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_op", 32'(alu_ctrl.op), 32'(ALU_ADD));
        chk("rst_src1", alu_ctrl.reg_src1, 32'd0);
        chk("rst_src2", alu_ctrl.reg_src2, 32'd0);
        dbg_chk("rst_dbg_x0", 5'd0, 32'd0);
        dbg_chk("rst_dbg_x1", 5'd1, RST_VAL);
        dbg_chk("rst_dbg_x31", 5'd31, RST_VAL);
        rst = 1'b1;
        model_reset();
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i].name, vecs[i].ins, vecs[i].ill, vecs[i].rd, vecs[i].data,
                      vecs[i].chk_alu, vecs[i].op, vecs[i].src2);
        end
        dbg_chk("tbl_dbg_x0", 5'd0, 32'd0);
        dbg_chk("tbl_dbg_x1", 5'd1, 32'hFFFF_FFFB);
        dbg_chk("tbl_dbg_x3", 5'd3, 32'hFFFF_FFFE);
        dbg_chk("tbl_dbg_x8_unchanged", 5'd8, RST_VAL);

        // Randomized instructions against the model
        for (int n = 0; n < 80; n++) begin
            k   = $urandom_range(0, 9);
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            f3  = 3'($urandom_range(0, 7));
            imm = 12'($urandom);
            if (k < 5) begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                if (k == 4) f7 = 7'($urandom);
                ins = enc_r(f7, rs2, rs1, f3, rd);
            end else if (k < 9) begin
                if (k != 8 && f3 == 3'd1) imm[11:5] = 7'h00;
                if (k != 8 && f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                ins = enc_i(imm, rs1, f3, rd);
            end else begin
                ins = $urandom;
            end
            ok = model_exec(ins, r);
            run_instr($sformatf("rnd%0d", n), ins, !ok, ins[11:7], r, 0, ALU_ADD, 32'd0);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_chk($sformatf("rnd_dbg_x%0d", i), 5'(i), mreg[i]);
        end

        // instr_valid held while busy: second word taken only back in IDLE
        wait_ready("hold");
        instr       = enc_i(12'd1, 5'd0, 3'd0, 5'd7);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr = enc_i(12'd2, 5'd0, 3'd0, 5'd8);
        @(negedge clk);
        chk("hold_ready_n1", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("hold_ready_n2", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("hold_wbv_n3", 32'(wb_valid), 32'd1);
        chk("hold_wb_rd_n3", 32'(wb_rd), 32'd7);
        chk("hold_wb_data_n3", wb_data, 32'd1);
        @(negedge clk);
        chk("hold_ready_n4", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("hold_ready_n5", 32'(instr_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("hold_wbv_n7", 32'(wb_valid), 32'd1);
        chk("hold_wb_rd_n7", 32'(wb_rd), 32'd8);
        chk("hold_wb_data_n7", wb_data, 32'd2);
        @(negedge clk);
        chk("hold_ready_n8", 32'(instr_ready), 32'd1);
        mreg[7] = 32'd1;
        mreg[8] = 32'd2;
        dbg_chk("hold_dbg_x7", 5'd7, 32'd1);
        dbg_chk("hold_dbg_x8", 5'd8, 32'd2);

        // Reset asserted during EXEC aborts the instruction
        wait_ready("rstex");
        instr       = enc_i(12'd9, 5'd0, 3'd0, 5'd6);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);  // DECODE
        @(negedge clk);  // EXEC
        chk("rstex_op_exec", 32'(alu_ctrl.op), 32'(ALU_ADD));
        chk("rstex_src2_exec", alu_ctrl.reg_src2, 32'd9);
        rst = 1'b0;
        @(negedge clk);
        chk("rstex_wbv_in_rst", 32'(wb_valid), 32'd0);
        chk("rstex_src2_in_rst", alu_ctrl.reg_src2, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstex_ready_after", 32'(instr_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rstex_wbv_%0d", i), 32'(wb_valid), 32'd0);
            chk($sformatf("rstex_illegal_%0d", i), 32'(illegal), 32'd0);
            @(negedge clk);
        end
        dbg_chk("rstex_dbg_x6", 5'd6, RST_VAL);
        dbg_chk("rstex_dbg_x1", 5'd1, RST_VAL);
        model_reset();
        run_instr("post_rst_addi", enc_i(12'h7FF, 5'd1, 3'd0, 5'd9), 0, 5'd9,
                  RST_VAL + 32'h7FF, 1, ALU_ADD, 32'h7FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
